fan_pwm_seq: RTL and testbench

FAN_PWM_SEQ -- requirements
Module: fan_pwm_seq

---
 rtl/fan_pwm_seq.sv | 128 ++++++++++++
 tb/tb_fan_pwm_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fan_pwm_seq.sv
// Fan PWM sequencer: kick-start at full duty, ramp one level per step toward the
// requested setting, and declare a stall when the tachometer stays silent.
module fan_pwm_seq #(
  parameter int unsigned PeriodCycles     = 2000,
  parameter int unsigned KickCycles       = 25000000,
  parameter int unsigned RampCycles       = 500000,
  parameter int unsigned TachWindowCycles = 50000000,
  parameter int unsigned FaultWindows     = 2
) (
  input  logic        soc_clk,
  input  logic        rst_n,
  input  logic [3:0]  pwm_setting_i,
  input  logic        tach_i,
  output logic        fan_pwm_o,
  output logic [3:0]  level_o,
  output logic [15:0] tach_count_o,
  output logic        fault_o
);

  localparam int unsigned PW = $clog2(PeriodCycles + 1);
  localparam int unsigned KW = $clog2(KickCycles + 1);
  localparam int unsigned RW = $clog2(RampCycles + 1);
  localparam int unsigned WW = $clog2(TachWindowCycles + 1);
  localparam int unsigned FW = $clog2(FaultWindows + 1);

  typedef enum logic [1:0] {KICK, RUN, FAULT} state_t;

  function automatic logic [16*PW-1:0] build_thr();
    logic [16*PW-1:0] t;
    t = '0;
    for (int unsigned l = 0; l < 16; l++)
      t[l*PW +: PW] = PW'((longint'(l) * longint'(PeriodCycles)) / 15);
    return t;
  endfunction

  // floor(L*PeriodCycles/15) for every level, resolved at elaboration
  localparam logic [16*PW-1:0] ThrTable = build_thr();

  state_t        r_state, w_state_nxt;
  logic [KW-1:0] r_kick_cnt;
  logic [RW-1:0] r_ramp_cnt;
  logic [3:0]    r_level, w_level_nxt, w_eff_nxt;
  logic [PW-1:0] r_per_cnt, r_thresh;
  logic          r_pwm;
  logic          r_tach_s1, r_tach_s2, r_tach_d;
  logic [WW-1:0] r_win_cnt;
  logic [15:0]   r_tach_cnt, r_tach_latch, w_tach_final;
  logic [FW-1:0] r_zero_cnt, w_zero_nxt;
  logic          r_fault;
  logic          w_wrap, w_win_end, w_tach_rise, w_ramp_tick;

  always_comb begin
    w_wrap       = (r_per_cnt == PW'(PeriodCycles - 1));
    w_win_end    = (r_win_cnt == WW'(TachWindowCycles - 1));
    w_tach_rise  = r_tach_s2 & ~r_tach_d;
    w_tach_final = (r_tach_cnt == 16'hFFFF) ? 16'hFFFF : r_tach_cnt + 16'(w_tach_rise);
    w_ramp_tick  = (r_state == RUN) && (r_ramp_cnt == RW'(RampCycles - 1));

    w_level_nxt = r_level;
    if (w_ramp_tick) begin
      if (pwm_setting_i > r_level)      w_level_nxt = r_level + 4'd1;
      else if (pwm_setting_i < r_level) w_level_nxt = r_level - 4'd1;
    end

    // Zero-window tracking runs in every state; only RUN acts on it
    w_zero_nxt = r_zero_cnt;
    if (w_win_end) begin
      if ((w_tach_final == 16'h0000) && (pwm_setting_i != 4'd0)) begin
        if (r_zero_cnt != FW'(FaultWindows)) w_zero_nxt = r_zero_cnt + FW'(1);
      end else begin
        w_zero_nxt = '0;
      end
    end

    w_state_nxt = r_state;
    case (r_state)
      KICK:    if (r_kick_cnt == KW'(KickCycles - 1)) w_state_nxt = RUN;
      RUN:     if (r_zero_cnt >= FW'(FaultWindows))   w_state_nxt = FAULT;
      FAULT:   if (w_win_end && (w_tach_final != 16'h0000)) w_state_nxt = RUN;
      default: w_state_nxt = KICK;
    endcase

    // Reload uses next-cycle level/state so a coincident ramp tick lands this wrap
    w_eff_nxt = (w_state_nxt == RUN) ? w_level_nxt : 4'hF;
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= KICK;
      r_kick_cnt   <= '0;
      r_ramp_cnt   <= '0;
      r_level      <= '0;
      r_per_cnt    <= '0;
      r_thresh     <= PW'(PeriodCycles);
      r_pwm        <= 1'b0;
      r_tach_s1    <= 1'b0;
      r_tach_s2    <= 1'b0;
      r_tach_d     <= 1'b0;
      r_win_cnt    <= '0;
      r_tach_cnt   <= '0;
      r_tach_latch <= '0;
      r_zero_cnt   <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kick_cnt <= (r_state == KICK) ? r_kick_cnt + KW'(1) : '0;
      r_ramp_cnt <= ((r_state != RUN) || w_ramp_tick) ? '0 : r_ramp_cnt + RW'(1);
      r_level    <= w_level_nxt;
      r_per_cnt  <= w_wrap ? '0 : r_per_cnt + PW'(1);
      if (w_wrap) r_thresh <= ThrTable[int'(w_eff_nxt)*PW +: PW];
      r_pwm      <= (r_per_cnt < r_thresh);
      r_tach_s1  <= tach_i;
      r_tach_s2  <= r_tach_s1;
      r_tach_d   <= r_tach_s2;
      r_win_cnt  <= w_win_end ? '0 : r_win_cnt + WW'(1);
      r_tach_cnt <= w_win_end ? '0 : w_tach_final;
      if (w_win_end) r_tach_latch <= w_tach_final;
      r_zero_cnt <= w_zero_nxt;
      r_fault    <= (w_state_nxt == FAULT);
    end
  end

  assign fan_pwm_o    = r_pwm;
  assign level_o      = r_level;
  assign tach_count_o = r_tach_latch;
  assign fault_o      = r_fault;

endmodule

// File: tb/tb_fan_pwm_seq.sv
// Scoreboard bench for fan_pwm_seq: per-period duty, ramp, stall/recovery,
// asynchronous reset and tach-count saturation.
module tb_fan_pwm_seq;

  logic        soc_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [3:0]  pwm_setting_i = 4'd0;
  logic        tach_i  = 1'b0;
  logic        fan_pwm_o;
  logic [3:0]  level_o;
  logic [15:0] tach_count_o;
  logic        fault_o;

  logic        clk2   = 1'b0;
  logic        rst2_n = 1'b0;
  logic        tach2  = 1'b0;
  logic        pwm2;
  logic [3:0]  lvl2;
  logic [15:0] tcnt2;
  logic        flt2;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        tach_run = 1'b0;
  logic [1:0]  tach_ph  = 2'd0;
  int          m_lvl;

  always #5 soc_clk = ~soc_clk;
  always #1 clk2 = ~clk2;

  fan_pwm_seq #(.PeriodCycles(20), .KickCycles(100), .RampCycles(40),
                .TachWindowCycles(200), .FaultWindows(2)) u_dut (
    .soc_clk(soc_clk), .rst_n(rst_n), .pwm_setting_i(pwm_setting_i), .tach_i(tach_i),
    .fan_pwm_o(fan_pwm_o), .level_o(level_o), .tach_count_o(tach_count_o), .fault_o(fault_o));

  fan_pwm_seq #(.PeriodCycles(20), .KickCycles(100), .RampCycles(40),
                .TachWindowCycles(140000), .FaultWindows(2)) u_sat (
    .soc_clk(clk2), .rst_n(rst2_n), .pwm_setting_i(4'd8), .tach_i(tach2),
    .fan_pwm_o(pwm2), .level_o(lvl2), .tach_count_o(tcnt2), .fault_o(flt2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (exp_q.size() == 0) check_val("sb_empty", 32'd1, 32'd0);
    else check_val(tag_q.pop_front(), got, exp_q.pop_front());
  endtask

  // One soc_clk edge passes; outputs are then stable for sampling
  task automatic tick();
    @(negedge soc_clk);
    if (tach_run) begin
      tach_ph = tach_ph + 2'd1;
      tach_i  = tach_ph[1];
    end
  endtask

  task automatic do_reset();
    @(negedge soc_clk);
    rst_n = 1'b0;
    tach_run = 1'b0;
    tach_i = 1'b0;
    #1;
    check_val("rst_outs", {fan_pwm_o, level_o, tach_count_o, fault_o}, 32'd0);
    repeat (3) @(negedge soc_clk);
    rst_n = 1'b1;
    m_lvl = 0;
  endtask

  // PWM period k covers edges 20k+1..20k+20 after reset release
  task automatic run_period(input int k);
    int eff, e, hi, rises;
    logic prev;
    eff = (k < 5) ? 15 : m_lvl;
    sb_push("hi", 32'(eff * 20 / 15));
    e = 20 * k + 20;
    if (e > 100 && ((e - 100) % 40) == 0) begin
      if (int'(pwm_setting_i) > m_lvl) m_lvl++;
      else if (int'(pwm_setting_i) < m_lvl) m_lvl--;
    end
    sb_push("lvl", 32'(m_lvl));
    sb_push("glitch", 32'd0);
    sb_push("fault", 32'd0);
    hi = 0; rises = 0; prev = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fan_pwm_o) hi++;
      if (fan_pwm_o && !prev) rises++;
      prev = fan_pwm_o;
    end
    sb_pop(32'(hi));
    sb_pop(32'(level_o));
    sb_pop(32'(rises));
    sb_pop(32'(fault_o));
  endtask

  task automatic run_fault(input logic [3:0] setting, input bit reset_mid);
    int hi;
    do_reset();
    pwm_setting_i = setting;
    tach_run = 1'b1;
    hi = 0;
    for (int cyc = 1; cyc <= 820; cyc++) begin
      if (cyc == 141) begin tach_run = 1'b0; tach_i = 1'b0; end
      if (cyc >= 650 && cyc < 674) tach_i = (((cyc - 650) / 4) % 2 == 0);
      if (cyc == 674) tach_i = 1'b0;
      tick();
      if (cyc == 400) begin sb_push("zero_win", 32'd0); sb_pop(32'(tach_count_o)); end
      if (cyc == 600) begin
        sb_push("pre_fault", 32'd0); sb_pop(32'(fault_o));
        sb_push("lvl_sat", 32'(setting)); sb_pop(32'(level_o));
      end
      if (cyc == 601) begin sb_push("fault_set", 32'd1); sb_pop(32'(fault_o)); end
      if (cyc >= 621 && cyc <= 640 && fan_pwm_o) hi++;
      if (cyc == 640) begin sb_push("fault_hi", 32'd20); sb_pop(32'(hi)); hi = 0; end
      if (reset_mid && cyc == 700) break;
      if (cyc == 800) begin
        sb_push("tach3", 32'd3); sb_pop(32'(tach_count_o));
        sb_push("fault_clr", 32'd0); sb_pop(32'(fault_o));
        sb_push("lvl_keep", 32'(setting)); sb_pop(32'(level_o));
      end
      if (cyc >= 801 && fan_pwm_o) hi++;
      if (cyc == 820) begin sb_push("run_hi", 32'(int'(setting) * 20 / 15)); sb_pop(32'(hi)); end
    end
    if (reset_mid) begin
      rst_n = 1'b0;
      #1;
      sb_push("rst_mid", 32'd0);
      sb_pop({fan_pwm_o, level_o, tach_count_o, fault_o});
      repeat (2) @(negedge soc_clk);
      rst_n = 1'b1;
      tick();
      sb_push("rel_pwm", 32'd1); sb_pop(32'(fan_pwm_o));
      hi = 1;
      for (int cyc = 2; cyc <= 120; cyc++) begin
        tick();
        if (fan_pwm_o) hi++;
        if (cyc == 100) begin sb_push("rekick_hi", 32'd100); sb_pop(32'(hi)); end
        if (cyc == 120) begin sb_push("post_kick", 32'd100); sb_pop(32'(hi)); end
      end
      sb_push("rekick_lvl", 32'd0); sb_pop(32'(level_o));
    end
  endtask

  initial begin
    // Setting 0: kick then constant low
    do_reset();
    pwm_setting_i = 4'd0;
    tach_run = 1'b1;
    for (int k = 0; k < 20; k++) run_period(k);

    // Full ramp 0 -> 15
    do_reset();
    pwm_setting_i = 4'd15;
    tach_run = 1'b1;
    for (int k = 0; k < 40; k++) run_period(k);

    // Retarget 15 -> 5 once level has reached 9
    do_reset();
    pwm_setting_i = 4'd15;
    tach_run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 24) begin
        check_val("lvl_before_retarget", 32'(level_o), 32'd9);
        pwm_setting_i = 4'd5;
      end
      run_period(k);
    end

    run_fault(4'd10, 1'b0);
    run_fault(4'd12, 1'b1);

    // Saturation on a second instance with an enlarged window and faster clock
    @(negedge clk2);
    rst2_n = 1'b1;
    for (int i = 1; i <= 140000; i++) begin
      @(negedge clk2);
      tach2 = ~tach2;
      if (i == 139999) begin sb_push("sat_pre", 32'd0); sb_pop(32'(tcnt2)); end
      if (i == 140000) begin sb_push("sat", 32'h0000FFFF); sb_pop(32'(tcnt2)); end
    end

    if (exp_q.size() != 0) check_val("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
